// File: rtl/vc_test_sink_pkg.sv
// Shared types and constants for the val/rdy test sink.
package vc_test_sink_pkg;

    typedef enum logic [1:0] {
        S_RECV = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } sink_state_t;

    localparam int unsigned       c_lfsr_nbits   = 16;
    localparam logic [15:0]       c_lfsr_seed    = 16'hACE1;
    // Galois feedback mask for taps 16,14,13,11 (right-shifting form)
    localparam logic [15:0]       c_lfsr_taps    = 16'hB400;
    localparam int unsigned       c_errcnt_nbits = 32;

    // Saturating increment for the error counter
    function automatic logic [c_errcnt_nbits-1:0] sat_inc(input logic [c_errcnt_nbits-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vc_test_sink_lfsr.sv
// 16-bit Galois LFSR used to draw random rdy-low gaps in the test sink.
module vc_test_sink_lfsr
    import vc_test_sink_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    output logic [c_lfsr_nbits-1:0] lfsr
);

    // Free-running shift every cycle out of reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= c_lfsr_seed;
        end else begin
            lfsr <= {1'b0, lfsr[c_lfsr_nbits-1:1]} ^ (lfsr[0] ? c_lfsr_taps : '0);
        end
    end

endmodule

// File: rtl/vc_test_sink_file.sv
// Test-harness val/rdy sink: checks received messages in order against a
// loaded expected list, counts mismatches and overflow transfers, raises done
// once every expected message has been accepted.
// Optional feature macro: VC_TEST_SINK_RAND_DELAY_EN (random rdy-low gaps).
module vc_test_sink_file
    import vc_test_sink_pkg::*;
#(
    parameter int unsigned  p_msg_nbits   = 1,
    parameter int unsigned  p_num_msgs    = 1024,
    parameter int unsigned  p_max_delay   = 0,
    localparam int unsigned c_index_nbits = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1
)(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      val,
    output logic                      rdy,
    input  logic [p_msg_nbits-1:0]    msg,
    output logic                      done,
    output logic                      err,
    output logic [c_errcnt_nbits-1:0] num_errs,
    output logic [c_index_nbits-1:0]  first_err
);

    localparam int unsigned c_count_nbits = c_index_nbits + 1;
    localparam int unsigned c_delay_nbits = $clog2(p_max_delay + 2);
    localparam logic [c_count_nbits-1:0] c_capacity = c_count_nbits'(p_num_msgs);

    // Expected-message memory and fill level; filled by the load tasks, untouched by reset
    logic [p_msg_nbits-1:0]   m [p_num_msgs];
    logic [c_count_nbits-1:0] index_max;

    sink_state_t               state, state_next;
    logic [c_index_nbits-1:0]  index, index_next;
    logic [c_delay_nbits-1:0]  delay_cnt, delay_next;
    logic [c_errcnt_nbits-1:0] num_errs_next;
    logic [c_index_nbits-1:0]  first_err_next;
    logic                      err_next;
    logic                      rdy_next;
    logic                      done_next;
    logic                      xfer;
    logic                      last;

`ifdef VC_TEST_SINK_RAND_DELAY_EN
    logic [c_lfsr_nbits-1:0]  lfsr;
    logic [c_delay_nbits-1:0] draw;

    vc_test_sink_lfsr u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .lfsr    (lfsr)
    );

    assign draw = c_delay_nbits'(lfsr % c_lfsr_nbits'(p_max_delay + 1));
`endif

    assign xfer = val && rdy;
    assign last = (c_count_nbits'(index) == (index_max - c_count_nbits'(1)));

    // Next-state, counters and next values of the registered outputs
    always_comb begin
        state_next     = state;
        index_next     = index;
        delay_next     = delay_cnt;
        num_errs_next  = num_errs;
        err_next       = err;
        first_err_next = first_err;

        case (state)
            S_RECV: begin
                if (index_max == '0) begin
                    state_next = S_DONE;
                end else if (xfer) begin
                    if (msg !== m[index]) begin
                        num_errs_next = sat_inc(num_errs);
                        err_next      = 1'b1;
                        if (!err) begin
                            first_err_next = index;
                        end
                    end
                    index_next = index + 1'b1;
                    if (last) begin
                        state_next = S_DONE;
                    end
`ifdef VC_TEST_SINK_RAND_DELAY_EN
                    else if (draw != '0) begin
                        state_next = S_WAIT;
                        delay_next = draw;
                    end
`endif
                end
            end
            S_WAIT: begin
                if (delay_cnt > c_delay_nbits'(1)) begin
                    delay_next = delay_cnt - 1'b1;
                end else begin
                    delay_next = '0;
                    state_next = S_RECV;
                end
            end
            S_DONE: begin
                if (xfer) begin
                    num_errs_next = sat_inc(num_errs);
                    err_next      = 1'b1;
                end
            end
            default: begin
                state_next = S_RECV;
            end
        endcase

        rdy_next  = (state_next != S_WAIT);
        done_next = (state_next == S_DONE);
    end

    // State, index, delay counter and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_RECV;
            index     <= '0;
            delay_cnt <= '0;
            rdy       <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            num_errs  <= '0;
            first_err <= '0;
        end else begin
            state     <= state_next;
            index     <= index_next;
            delay_cnt <= delay_next;
            rdy       <= rdy_next;
            done      <= done_next;
            err       <= err_next;
            num_errs  <= num_errs_next;
            first_err <= first_err_next;
        end
    end

    // A val that is X outside reset means the upstream harness is broken
    vc_assert_not_x: assert property (@(posedge clk) disable iff (!reset_n) !$isunknown(val));

    // Empty the expected list
    task automatic clear_msgs();
        index_max = '0;
    endtask

    // Append one value to the expected list
    task automatic push_msg(input logic [p_msg_nbits-1:0] value);
        if (index_max < c_capacity) begin
            m[index_max[c_index_nbits-1:0]] = value;
            index_max = index_max + 1'b1;
        end
    endtask

endmodule

// File: tb/tb_vc_test_sink_file.sv
// Scoreboard bench for vc_test_sink_file: expected status after each transfer
// is queued when the message is driven and compared right after the transfer.
module tb_vc_test_sink_file;

    localparam int unsigned c_msg_nbits = 8;
    localparam int unsigned c_num_msgs  = 32;
    localparam int unsigned c_max_delay = 3;
    localparam int unsigned c_idx_nbits = 5;
    localparam int          c_wait_max  = 50;
`ifdef VC_TEST_SINK_RAND_DELAY_EN
    localparam int          c_gap_limit = 3;
`else
    localparam int          c_gap_limit = 0;
`endif

    typedef struct {
        logic [31:0]            errs;
        logic                   err;
        logic [c_idx_nbits-1:0] first;
        logic                   chk_first;
        logic                   done;
    } exp_t;

    logic                   clk;
    logic                   reset_n;
    logic                   val;
    logic                   rdy;
    logic [c_msg_nbits-1:0] msg;
    logic                   done;
    logic                   err;
    logic [31:0]            num_errs;
    logic [c_idx_nbits-1:0] first_err;

    int errors = 0;
    int checks = 0;

    exp_t                   sb [$];
    logic [c_msg_nbits-1:0] stim [$];
    logic [c_msg_nbits-1:0] exp_mem [$];
    int                     model_idx;
    logic [31:0]            model_errs;
    logic                   model_err;
    logic                   model_mm;
    logic [c_idx_nbits-1:0] model_first;

    vc_test_sink_file #(
        .p_msg_nbits (c_msg_nbits),
        .p_num_msgs  (c_num_msgs),
        .p_max_delay (c_max_delay)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .val       (val),
        .rdy       (rdy),
        .msg       (msg),
        .done      (done),
        .err       (err),
        .num_errs  (num_errs),
        .first_err (first_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rdy"},       32'(rdy),       32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_err"},       32'(err),       32'd0);
        check({tag, "_num_errs"},  num_errs,       32'd0);
        check({tag, "_first_err"}, 32'(first_err), 32'd0);
    endtask

    task automatic model_reset();
        model_idx   = 0;
        model_errs  = 0;
        model_err   = 1'b0;
        model_mm    = 1'b0;
        model_first = '0;
        sb.delete();
    endtask

    task automatic assert_reset(input string tag);
        @(negedge clk);
        val     = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_state(tag);
        model_reset();
    endtask

    task automatic release_reset(input bit settle);
        @(negedge clk);
        reset_n = 1'b1;
        if (settle) @(negedge clk);
    endtask

    task automatic load_stim();
        dut.clear_msgs();
        exp_mem.delete();
        foreach (stim[i]) begin
            dut.push_msg(stim[i]);
            exp_mem.push_back(stim[i]);
        end
    endtask

    // Drive one message at a negedge, wait for rdy, then check status after the transfer
    task automatic send_msg(input logic [c_msg_nbits-1:0] v);
        int   gap;
        exp_t e;
        exp_t got;
        val = 1'b1;
        msg = v;
        gap = 0;
        while (rdy !== 1'b1 && gap < c_wait_max) begin
            @(negedge clk);
            gap++;
        end
        if (gap >= c_wait_max) begin
            check("rdy_timeout", 32'(gap), 32'd0);
            return;
        end
        check("rdy_gap", 32'(gap <= c_gap_limit), 32'd1);

        if (model_idx < exp_mem.size()) begin
            if (v !== exp_mem[model_idx]) begin
                model_errs = model_errs + 1;
                if (!model_err) begin
                    model_first = c_idx_nbits'(model_idx);
                    model_mm    = 1'b1;
                end
                model_err = 1'b1;
            end
            model_idx++;
        end else begin
            model_errs = model_errs + 1;
            model_err  = 1'b1;
        end
        e.errs      = model_errs;
        e.err       = model_err;
        e.first     = model_first;
        e.chk_first = model_mm;
        e.done      = (model_idx == exp_mem.size());
        sb.push_back(e);

        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check("num_errs", num_errs, got.errs);
            check("err", 32'(err), 32'(got.err));
            if (got.chk_first) check("first_err", 32'(first_err), 32'(got.first));
            check("done", 32'(done), 32'(got.done));
        end
        @(negedge clk);
    endtask

    task automatic send_stim();
        foreach (stim[i]) send_msg(stim[i]);
        val = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1;
        val     = 1'b0;
        msg     = '0;
        model_reset();

        // Back-to-back in-order stream
        assert_reset("rst1");
        stim = {8'h0A, 8'h0B, 8'h0C};
        load_stim();
        release_reset(1'b1);
        send_stim();
        check("t1_rdy_after", 32'(rdy), 32'd1);

        // One mismatch in the middle
        assert_reset("rst2");
        stim = {8'h01, 8'h02, 8'h03};
        load_stim();
        release_reset(1'b1);
        stim = {8'h01, 8'hFF, 8'h03};
        send_stim();

        // Overflow transfer after done
        assert_reset("rst3");
        stim = {8'h05};
        load_stim();
        release_reset(1'b1);
        stim = {8'h05, 8'h06};
        send_stim();
        check("t3_rdy_in_done", 32'(rdy), 32'd1);

        // Asynchronous reset mid-stream, then full restart from the first entry
        assert_reset("rst4");
        stim = {8'h11, 8'h22, 8'h33, 8'h44};
        load_stim();
        release_reset(1'b1);
        send_msg(8'h11);
        send_msg(8'h22);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("mid_rst");
        val = 1'b0;
        model_reset();
        release_reset(1'b1);
        send_stim();

        // Empty expected list: done on the first edge out of reset
        assert_reset("rst5");
        stim.delete();
        load_stim();
        release_reset(1'b0);
        check("t5_done_before", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check("t5_done", 32'(done), 32'd1);
        check("t5_rdy", 32'(rdy), 32'd1);
        check("t5_num_errs", num_errs, 32'd0);

        // Twenty random messages with val held high
        assert_reset("rst6");
        stim.delete();
        for (int i = 0; i < 20; i++) stim.push_back(c_msg_nbits'($urandom_range(0, 255)));
        load_stim();
        release_reset(1'b1);
        send_stim();
        check("t6_err", 32'(err), 32'd0);
        check("t6_done", 32'(done), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
